// File: rtl/kmeans_pkg.sv
// Shared definitions for the k-means point RAM scan controller.
package kmeans_pkg;
  localparam int ADDR_W = 8;
  localparam int DATA_W = 91;

  typedef enum logic [1:0] {IDLE, SCAN, DRAIN, DONE} scan_state_t;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic              last;
  } point_entry_t;
endpackage

// File: rtl/ram_scan_ctrl_if.sv
// Host write port, point stream to the k-means core and point RAM bus.
interface ram_scan_ctrl_if #(
  parameter int addrWidth = kmeans_pkg::ADDR_W,
  parameter int dataWidth = kmeans_pkg::DATA_W
) ();
  logic                 host_wr_req;
  logic [addrWidth-1:0] host_wr_addr;
  logic [dataWidth-1:0] host_wr_data;
  logic                 host_wr_ack;
  logic                 host_wr_err;

  logic                 pt_valid;
  logic                 pt_ready;
  logic [dataWidth-1:0] pt_data;
  logic [addrWidth-1:0] pt_addr;
  logic                 pt_last;

  logic                 ram_cs;
  logic                 ram_we;
  logic [addrWidth-1:0] ram_addr;
  logic [dataWidth-1:0] ram_wdata;
  logic [dataWidth-1:0] ram_rdata;

  modport master (
    input  host_wr_req, host_wr_addr, host_wr_data, pt_ready, ram_rdata,
    output host_wr_ack, host_wr_err, pt_valid, pt_data, pt_addr, pt_last,
           ram_cs, ram_we, ram_addr, ram_wdata
  );

  modport slave (
    output host_wr_req, host_wr_addr, host_wr_data, pt_ready, ram_rdata,
    input  host_wr_ack, host_wr_err, pt_valid, pt_data, pt_addr, pt_last,
           ram_cs, ram_we, ram_addr, ram_wdata
  );
endinterface

// File: rtl/point_fifo.sv
// Two-entry synchronous FIFO with flush; caller guarantees no push when full.
module point_fifo #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] push_data,
  output logic [WIDTH-1:0] head,
  output logic [1:0]       count
);
  logic [WIDTH-1:0] mem [2];
  logic             wr_ptr;
  logic             rd_ptr;

  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) wr_ptr <= !wr_ptr;
      if (pop)  rd_ptr <= !rd_ptr;
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  assign head = mem[rd_ptr];
endmodule

// File: rtl/ram_scan_ctrl.sv
// Point RAM owner: host indirect writes in idle, windowed streaming scan on start.
module ram_scan_ctrl
  import kmeans_pkg::*;
#(
  parameter int addrWidth = ADDR_W,
  parameter int dataWidth = DATA_W
) (
  input  logic                 clk,
  input  logic                 rst_n,
  ram_scan_ctrl_if.master      bus,
  input  logic                 scan_start,
  input  logic [addrWidth-1:0] first_addr,
  input  logic [addrWidth-1:0] last_addr,
  output logic                 scan_busy,
  output logic                 scan_done
);
  typedef struct packed {
    logic [addrWidth-1:0] addr;
    logic [dataWidth-1:0] data;
    logic                 last;
  } entry_t;
  localparam int EW = $bits(entry_t);

  scan_state_t          state_q, state_d;
  logic [addrWidth-1:0] rd_ptr_q, last_q;
  logic                 start_q, ack_q, err_q;
  logic                 issue, pop, fifo_push, fifo_pop, start_edge, credit;
  logic [1:0]           fifo_count;
  entry_t               fifo_head, incoming, head;

  // Read stage: address/last travel alongside the RAM access, data returns a cycle later
  logic                 vld_p1;
  logic [addrWidth-1:0] addr_p1;
  logic                 last_p1;

  assign start_edge = scan_start && !start_q;
  assign credit     = (fifo_count == 2'd0) || (fifo_count == 2'd1 && !vld_p1);
  assign incoming   = {addr_p1, bus.ram_rdata, last_p1};

  // An empty buffer lets returning read data bypass straight to the core.
  always_comb begin
    if (fifo_count != 2'd0) head = fifo_head;
    else if (vld_p1)        head = incoming;
    else                    head = '0;
  end

  assign bus.pt_valid = (fifo_count != 2'd0) || vld_p1;
  assign bus.pt_data  = head.data;
  assign bus.pt_addr  = head.addr;
  assign bus.pt_last  = head.last;
  assign pop          = bus.pt_valid && bus.pt_ready;
  assign fifo_pop     = pop && (fifo_count != 2'd0);
  assign fifo_push    = vld_p1 && !(pop && fifo_count == 2'd0);

  point_fifo #(.WIDTH(EW)) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (state_q == DONE),
    .push      (fifo_push),
    .pop       (fifo_pop),
    .push_data (incoming),
    .head      (fifo_head),
    .count     (fifo_count)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d       = state_q;
    issue         = 1'b0;
    bus.ram_cs    = 1'b0;
    bus.ram_we    = 1'b0;
    bus.ram_addr  = '0;
    bus.ram_wdata = '0;
    case (state_q)
      IDLE: begin
        if (bus.host_wr_req) begin
          bus.ram_cs    = 1'b1;
          bus.ram_we    = 1'b1;
          bus.ram_addr  = bus.host_wr_addr;
          bus.ram_wdata = bus.host_wr_data;
        end
        if (start_edge) state_d = SCAN;
      end
      SCAN: begin
        if (credit) begin
          issue        = 1'b1;
          bus.ram_cs   = 1'b1;
          bus.ram_addr = rd_ptr_q;
          if (rd_ptr_q == last_q) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (pop && head.last) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_p1  <= 1'b0;
      start_q <= 1'b0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      vld_p1  <= issue;
      start_q <= scan_start;
      ack_q   <= bus.host_wr_req && (state_q == IDLE);
      err_q   <= bus.host_wr_req && (state_q != IDLE);
    end
  end

  always_ff @(posedge clk) begin
    if (state_q == IDLE && start_edge) begin
      rd_ptr_q <= first_addr;
      last_q   <= last_addr;
    end else if (issue) begin
      rd_ptr_q <= rd_ptr_q + addrWidth'(1);
    end
    if (issue) begin
      addr_p1 <= rd_ptr_q;
      last_p1 <= (rd_ptr_q == last_q);
    end
  end

  assign bus.host_wr_ack = ack_q;
  assign bus.host_wr_err = err_q;
  assign scan_busy       = (state_q != IDLE);
  assign scan_done       = (state_q == DONE);
endmodule
